// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device transmitter sending one byte with open-drain line control
//   CLK, reset               : system clock, synchronous active-high reset
//   PS2_CLK, PS2_DATA        : sensed PS/2 lines (asynchronous to CLK)
//   oPS2_CLK_OE, oPS2_DATA_OE: 1 = pull the line low, 0 = release it
//   iData, iStart            : byte to send and single-cycle request, accepted only in IDLE
//   oBusy, oDone, oErr       : transfer in progress, one-cycle completion pulse, NACK/timeout flag
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int TMR_W = 20
) (
  input  logic       CLK,
  input  logic       reset,
  input  logic       PS2_CLK,
  input  logic       PS2_DATA,
  output logic       oPS2_CLK_OE,
  output logic       oPS2_DATA_OE,
  input  logic [7:0] iData,
  input  logic       iStart,
  output logic       oBusy,
  output logic       oDone,
  output logic       oErr
);
  typedef enum logic [2:0] {IDLE, INHIBIT, SEND, ACK, WAIT_IDLE} state_t;
  localparam logic [TMR_W-1:0] INH_LAST = TMR_W'(INHIBIT_CYCLES - 1);
  localparam logic [TMR_W-1:0] TO_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
  state_t state, state_nxt;
  logic [1:0] clk_sync, data_sync;
  logic clk_prev;
  logic fe, line_idle, inh_done, watched, timeout;
  logic [TMR_W-1:0] tmr;
  logic [3:0] bitcnt;
  logic [9:0] shreg;
  logic ack_ok;
  logic clk_oe_nxt, data_oe_nxt, busy_nxt, done_nxt, err_nxt;
  assign fe = clk_prev & ~clk_sync[1];
  assign line_idle = clk_sync[1] & data_sync[1];
  assign inh_done = tmr == INH_LAST;
  assign watched = state inside {SEND, ACK, WAIT_IDLE};
  // a device edge in the same cycle proves the device is alive, so it beats the watchdog
  assign timeout = watched && !fe && tmr == TO_LAST;
  always_ff @(posedge CLK) begin
    if (reset) begin
      state <= IDLE;
      clk_sync <= 2'b11;
      data_sync <= 2'b11;
      clk_prev <= 1'b1;
      tmr <= '0;
      bitcnt <= '0;
      shreg <= '0;
      ack_ok <= 1'b0;
      oPS2_CLK_OE <= 1'b0;
      oPS2_DATA_OE <= 1'b0;
      oBusy <= 1'b0;
      oDone <= 1'b0;
      oErr <= 1'b0;
    end else begin
      state <= state_nxt;
      clk_sync <= {clk_sync[0], PS2_CLK};
      data_sync <= {data_sync[0], PS2_DATA};
      clk_prev <= clk_sync[1];
      // one counter serves as inhibit timer and as inter-edge watchdog
      tmr <= ((state == INHIBIT && !inh_done) || (watched && !fe)) ? tmr + TMR_W'(1) : '0;
      bitcnt <= state != SEND ? 4'd0 : fe ? bitcnt + 4'd1 : bitcnt;
      // frame bits after the start bit, LSB first: D0..D7, odd parity, stop
      shreg <= (state == IDLE && iStart) ? {1'b1, ~^iData, iData} :
               (state == SEND && fe) ? {1'b0, shreg[9:1]} : shreg;
      ack_ok <= (state == ACK && fe) ? ~data_sync[1] : ack_ok;
      oPS2_CLK_OE <= clk_oe_nxt;
      oPS2_DATA_OE <= data_oe_nxt;
      oBusy <= busy_nxt;
      oDone <= done_nxt;
      oErr <= err_nxt;
    end
  end
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      state_nxt = iStart ? INHIBIT : IDLE;
      INHIBIT:   state_nxt = inh_done ? SEND : INHIBIT;
      SEND:      state_nxt = (fe && bitcnt == 4'd9) ? ACK : timeout ? IDLE : SEND;
      ACK:       state_nxt = fe ? WAIT_IDLE : timeout ? IDLE : ACK;
      WAIT_IDLE: state_nxt = (line_idle || timeout) ? IDLE : WAIT_IDLE;
      default:   state_nxt = IDLE;
    endcase
  end
  always_comb begin
    clk_oe_nxt = (state == IDLE && iStart) || (state == INHIBIT && !inh_done);
    // start bit goes low in the same update that releases the clock
    data_oe_nxt = state == INHIBIT ? inh_done :
                  (state == SEND && !timeout) ? (fe ? ~shreg[0] : oPS2_DATA_OE) : 1'b0;
    busy_nxt = state_nxt != IDLE;
    done_nxt = state != IDLE && state_nxt == IDLE;
    err_nxt = done_nxt && !(state == WAIT_IDLE && line_idle && ack_ok);
  end
endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: self-checking bench for ps2_host_tx with an emulated PS/2 device
module tb_ps2_host_tx;
  logic CLK = 1'b0;
  logic reset;
  logic dev_clk, dev_data;
  logic PS2_CLK, PS2_DATA;
  logic oPS2_CLK_OE, oPS2_DATA_OE;
  logic [7:0] iData;
  logic iStart;
  logic oBusy, oDone, oErr;
  int n_chk = 0;
  int n_fail = 0;
  int inh_cnt = 0;
  int done_cnt = 0;
  int viol = 0;
  logic [9:0] r_bits;
  int r_inh, r_lat;
  bit r_done, r_err, r_busy, r_released;
  logic [1:0] r_oe;
  typedef struct {
    logic [7:0] d;
    bit ack;
    logic [9:0] bits;
    bit err;
  } vec_t;
  vec_t vecs[4];
  ps2_host_tx #(.INHIBIT_CYCLES(10), .TIMEOUT_CYCLES(200), .TMR_W(20)) dut (
    .CLK(CLK), .reset(reset), .PS2_CLK(PS2_CLK), .PS2_DATA(PS2_DATA),
    .oPS2_CLK_OE(oPS2_CLK_OE), .oPS2_DATA_OE(oPS2_DATA_OE),
    .iData(iData), .iStart(iStart), .oBusy(oBusy), .oDone(oDone), .oErr(oErr)
  );
  assign PS2_CLK = dev_clk & ~oPS2_CLK_OE;
  assign PS2_DATA = dev_data & ~oPS2_DATA_OE;
  always #5 CLK = ~CLK;
  always @(negedge CLK) begin
    if (oPS2_CLK_OE) inh_cnt++;
    if (oDone) done_cnt++;
    if (oErr && !oDone) viol++;
    if (oPS2_CLK_OE && oPS2_DATA_OE) viol++;
  end
  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish within the time limit");
    $fatal(1);
  end
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  function automatic logic [9:0] model_frame(input logic [7:0] d);
    int ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(d[i]);
    return {1'b1, (ones % 2 == 0) ? 1'b1 : 1'b0, d};
  endfunction
  task automatic run_tx(input logic [7:0] d, input bit ack, input bit dev_on, input bit skip_start,
                        input bit poke, input bit chain, input logic [7:0] chain_d, input int abort_at);
    r_bits = '0; r_done = 0; r_err = 0; r_busy = 1; r_lat = 0; r_released = 0; r_oe = 2'b11;
    if (!skip_start) begin
      @(negedge CLK); iData = d; iStart = 1'b1; inh_cnt = 0;
      @(negedge CLK); iStart = 1'b0; iData = 8'($urandom);
    end
    for (int i = 0; i < 100 && !r_released; i++)
      if (!oPS2_CLK_OE && oPS2_DATA_OE) r_released = 1; else @(negedge CLK);
    check("host_release", 32'(r_released), 1);
    if (!r_released) return;
    r_inh = inh_cnt;
    if (dev_on) begin
      repeat (20) @(negedge CLK);
      for (int k = 0; k < 10; k++) begin
        dev_clk = 1'b0;
        if (k + 1 == abort_at) begin
          repeat (2) @(negedge CLK);
          reset = 1'b1;
          @(negedge CLK); reset = 1'b0;
          check("abort_clk_oe", 32'(oPS2_CLK_OE), 0);
          check("abort_data_oe", 32'(oPS2_DATA_OE), 0);
          check("abort_busy", 32'(oBusy), 0);
          check("abort_done", 32'(oDone), 0);
          dev_clk = 1'b1;
          return;
        end
        if (poke && k == 2) begin
          @(negedge CLK); iData = 8'h55; iStart = 1'b1;
          @(negedge CLK); iStart = 1'b0;
          repeat (18) @(negedge CLK);
        end else repeat (20) @(negedge CLK);
        r_bits[k] = PS2_DATA;
        dev_clk = 1'b1;
        repeat (20) @(negedge CLK);
      end
      dev_data = !ack;
      repeat (5) @(negedge CLK);
      dev_clk = 1'b0;
      repeat (20) @(negedge CLK);
      dev_clk = 1'b1; dev_data = 1'b1;
      while (!oDone && r_lat < 60) begin @(negedge CLK); r_lat++; end
    end else
      while (!oDone && r_lat < 400) begin @(negedge CLK); r_lat++; end
    r_done = oDone; r_err = oErr; r_busy = oBusy; r_oe = {oPS2_CLK_OE, oPS2_DATA_OE};
    if (chain) begin iData = chain_d; iStart = 1'b1; inh_cnt = 0; end
    @(negedge CLK); iStart = 1'b0;
    check("done_one_cycle", 32'(oDone), 0);
  endtask
  task automatic check_tx(input string tag, input logic [9:0] eb, input bit ee);
    check({tag, "_inhibit_len"}, r_inh, 10);
    check({tag, "_bits"}, 32'(r_bits), 32'(eb));
    check({tag, "_done"}, 32'(r_done), 1);
    check({tag, "_err"}, 32'(r_err), 32'(ee));
    check({tag, "_busy_at_done"}, 32'(r_busy), 0);
    check({tag, "_oe_at_done"}, 32'(r_oe), 0);
  endtask
  initial begin
    int done_before;
    logic [7:0] rd;
    bit rack;
    vecs[0] = '{d: 8'hED, ack: 1'b1, bits: 10'h3ED, err: 1'b0};
    vecs[1] = '{d: 8'h07, ack: 1'b1, bits: 10'h207, err: 1'b0};
    vecs[2] = '{d: 8'h00, ack: 1'b0, bits: 10'h300, err: 1'b1};
    vecs[3] = '{d: 8'hFF, ack: 1'b1, bits: 10'h3FF, err: 1'b0};
    reset = 1'b1; iStart = 1'b0; iData = '0; dev_clk = 1'b1; dev_data = 1'b1;
    repeat (3) @(negedge CLK);
    check("rst_clk_oe", 32'(oPS2_CLK_OE), 0);
    check("rst_data_oe", 32'(oPS2_DATA_OE), 0);
    check("rst_busy", 32'(oBusy), 0);
    check("rst_done", 32'(oDone), 0);
    check("rst_err", 32'(oErr), 0);
    reset = 1'b0;
    repeat (3) @(negedge CLK);
    for (int i = 0; i < 4; i++) begin
      run_tx(vecs[i].d, vecs[i].ack, 1, 0, 0, 0, 8'h00, 0);
      check_tx($sformatf("vec%0d", i), vecs[i].bits, vecs[i].err);
      repeat (5) @(negedge CLK);
    end
    run_tx(8'hA5, 1, 0, 0, 0, 0, 8'h00, 0);
    check("timeout_inhibit_len", r_inh, 10);
    check("timeout_latency", r_lat, 200);
    check("timeout_done", 32'(r_done), 1);
    check("timeout_err", 32'(r_err), 1);
    check("timeout_busy", 32'(r_busy), 0);
    check("timeout_oe", 32'(r_oe), 0);
    repeat (5) @(negedge CLK);
    run_tx(8'hED, 1, 1, 0, 1, 1, 8'hF4, 0);
    check_tx("poke", 10'h3ED, 0);
    run_tx(8'h00, 1, 1, 1, 0, 0, 8'h00, 0);
    check_tx("chain", 10'h2F4, 0);
    repeat (5) @(negedge CLK);
    done_before = done_cnt;
    run_tx(8'h3C, 1, 1, 0, 0, 0, 8'h00, 5);
    repeat (50) @(negedge CLK);
    check("abort_no_done", done_cnt, done_before);
    check("abort_idle_busy", 32'(oBusy), 0);
    run_tx(8'h3C, 1, 1, 0, 0, 0, 8'h00, 0);
    check_tx("after_reset", 10'h33C, 0);
    for (int i = 0; i < 6; i++) begin
      rd = 8'($urandom_range(0, 255));
      rack = 1'($urandom_range(0, 1));
      repeat (5) @(negedge CLK);
      run_tx(rd, rack, 1, 0, 0, 0, 8'h00, 0);
      check_tx($sformatf("rand%0d_%02h", i, rd), model_frame(rd), !rack);
    end
    check("protocol_violations", viol, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
